// File: rtl/keccak_pkg.sv
// Shared constants, types and helpers for the Keccak-p permutation core
// and its combinational round.
package keccak_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } perm_state_e;

   localparam int NUM_LANES = 25;
   localparam int NUM_RC    = 24;
   localparam int RC_W      = 7;
   localparam int CTR_W     = 5;

   // Bit j of each entry is XORed into lane (0,0) bit 2^j-1.
   localparam logic [RC_W-1:0] RC_TABLE [NUM_RC] = '{
      7'h01, 7'h1A, 7'h5E, 7'h70, 7'h1F, 7'h21, 7'h79, 7'h55,
      7'h0E, 7'h0C, 7'h35, 7'h26, 7'h3F, 7'h4F, 7'h5D, 7'h53,
      7'h52, 7'h48, 7'h16, 7'h66, 7'h79, 7'h58, 7'h21, 7'h74
   };

   // Indexed [x][y]; 64-bit offsets, reduced mod LANE_W where used.
   localparam int RHO_OFS [5][5] = '{
      '{ 0, 36,  3, 41, 18},
      '{ 1, 44, 10, 45,  2},
      '{62,  6, 43, 15, 61},
      '{28, 55, 25, 21, 56},
      '{27, 20, 39,  8, 14}
   };

   function automatic int lane_log2(input int lane_w);
      int l;
      l = 0;
      for (int i = 0; i < 7; i++)
         if ((1 << i) == lane_w) l = i;
      return l;
   endfunction

   function automatic int max_rounds(input int lane_w);
      return 12 + 2 * lane_log2(lane_w);
   endfunction

   function automatic int lane_idx(input int x, input int y);
      return 5 * (y % 5) + (x % 5);
   endfunction

   function automatic int state_width(input int lane_w);
      return NUM_LANES * lane_w;
   endfunction

endpackage

// File: rtl/keccak_round_p.sv
// One combinational Keccak-p round (theta, rho, pi, chi, iota) on a
// packed 25-lane state.
module keccak_round_p
   import keccak_pkg::*;
#(
   parameter int LANE_W = 64
) (
   input  logic [NUM_LANES*LANE_W-1:0] state,
   input  logic [RC_W-1:0]             rc,
   output logic [NUM_LANES*LANE_W-1:0] state_next
);

   localparam int L = lane_log2(LANE_W);

   logic [LANE_W-1:0] a [NUM_LANES];
   logic [LANE_W-1:0] b [NUM_LANES];
   logic [LANE_W-1:0] e [NUM_LANES];
   logic [LANE_W-1:0] c [5];
   logic [LANE_W-1:0] d [5];
   logic              unused_rc;

   // Narrow lanes only consume rc[L:0].
   assign unused_rc = ^rc;

   function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int r);
      return (v << r) | (v >> (LANE_W - r));
   endfunction

   always_comb begin
      b          = '{default: '0};
      state_next = '0;
      for (int i = 0; i < NUM_LANES; i++) a[i] = state[i*LANE_W +: LANE_W];
      for (int x = 0; x < 5; x++)
         c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
      for (int x = 0; x < 5; x++)
         d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
      // theta column mix folded into the rho/pi move
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            b[lane_idx(y, 2*x + 3*y)] = rotl(a[lane_idx(x, y)] ^ d[x], RHO_OFS[x][y] % LANE_W);
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            e[lane_idx(x, y)] = b[lane_idx(x, y)] ^ (~b[lane_idx(x+1, y)] & b[lane_idx(x+2, y)]);
      for (int j = 0; j <= L; j++)
         e[0][(1 << j) - 1] = e[0][(1 << j) - 1] ^ rc[j];
      for (int i = 0; i < NUM_LANES; i++) state_next[i*LANE_W +: LANE_W] = e[i];
   end

endmodule

// File: rtl/keccak_perm_core.sv
// Iterative Keccak-p[25*LANE_W, NUM_ROUNDS] engine, UNROLL rounds per clock,
// valid/ready on input and output.
// state   | meaning
// ST_IDLE | in_ready high, waiting for in_valid
// ST_RUN  | applying UNROLL rounds per clock
// ST_DONE | out_valid high, holding result until out_ready
module keccak_perm_core
   import keccak_pkg::*;
#(
   parameter int LANE_W     = 64,
   parameter int NUM_ROUNDS = 24,
   parameter int UNROLL     = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_LANES*LANE_W-1:0] in_state,
   input  logic                        abort,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUM_LANES*LANE_W-1:0] out_state,
   output logic                        busy
);

   localparam int SW = state_width(LANE_W);
   // Reduced-round variants run the tail of the round schedule.
   localparam int R0 = max_rounds(LANE_W) - NUM_ROUNDS;

   if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane_w
      $error("keccak_perm_core: LANE_W must be 8, 16, 32 or 64");
   end
   if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
      $error("keccak_perm_core: UNROLL must be 1..4");
   end
   if (NUM_ROUNDS < 1 || NUM_ROUNDS > max_rounds(LANE_W)) begin : g_bad_rounds
      $error("keccak_perm_core: NUM_ROUNDS out of range for LANE_W");
   end
   if (NUM_ROUNDS % UNROLL != 0) begin : g_bad_multiple
      $error("keccak_perm_core: NUM_ROUNDS must be a multiple of UNROLL");
   end

   perm_state_e      fsm_q, fsm_d;
   logic [CTR_W-1:0] round_ctr_q, round_ctr_d;
   logic [SW-1:0]    state_q, state_d;
   logic [CTR_W-1:0] rc_idx   [UNROLL];
   logic [RC_W-1:0]  rc_stage [UNROLL];
   logic [SW-1:0]    chain    [UNROLL+1];
   logic             last_step;

   always_comb begin
      for (int k = 0; k < UNROLL; k++) begin
         rc_idx[k]   = round_ctr_q + CTR_W'(R0 + k);
         rc_stage[k] = '0;
         if (rc_idx[k] < CTR_W'(NUM_RC)) rc_stage[k] = RC_TABLE[rc_idx[k]];
      end
   end

   assign chain[0] = state_q;

   for (genvar k = 0; k < UNROLL; k++) begin : g_round
      keccak_round_p #(.LANE_W(LANE_W)) u_round (
         .state      (chain[k]),
         .rc         (rc_stage[k]),
         .state_next (chain[k+1])
      );
   end

   assign last_step = (round_ctr_q + CTR_W'(UNROLL)) == CTR_W'(NUM_ROUNDS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= ST_IDLE;
         round_ctr_q <= '0;
         state_q     <= '0;
      end else begin
         fsm_q       <= fsm_d;
         round_ctr_q <= round_ctr_d;
         state_q     <= state_d;
      end
   end

   always_comb begin
      fsm_d       = fsm_q;
      round_ctr_d = round_ctr_q;
      state_d     = state_q;
      case (fsm_q)
         ST_IDLE: begin
            if (!abort && in_valid) begin
               state_d     = in_state;
               round_ctr_d = '0;
               fsm_d       = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d     = '0;
               round_ctr_d = '0;
               fsm_d       = ST_IDLE;
            end else begin
               state_d     = chain[UNROLL];
               round_ctr_d = round_ctr_q + CTR_W'(UNROLL);
               if (last_step) fsm_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (abort) begin
               state_d     = '0;
               round_ctr_d = '0;
               fsm_d       = ST_IDLE;
            end else if (out_ready) begin
               fsm_d = ST_IDLE;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (fsm_q)
         ST_IDLE: in_ready  = 1'b1;
         ST_RUN:  busy      = 1'b1;
         ST_DONE: out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   assign out_state = state_q;

endmodule

// File: tb/tb_keccak_perm_core.sv
// Bench for keccak_perm_core: seven parameter sets run in lockstep against a
// software Keccak-p built from the LFSR round constants and the rho walk.
`timescale 1ns/1ps
module tb_keccak_perm_core;

   localparam int NCFG = 7;
   localparam int W_T  [NCFG] = '{64, 64, 64,  8, 16, 32, 64};
   localparam int NR_T [NCFG] = '{24, 24, 24, 18, 20, 22, 12};
   localparam int U_T  [NCFG] = '{ 1,  2,  4,  1,  1,  1,  1};

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            abort;
   logic            out_ready;
   logic [1599:0]   in_state;
   logic [NCFG-1:0] ir_v, ov_v, bz_v;
   logic [1599:0]   os_a [NCFG];
   int              checks = 0;
   int              errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NCFG; g++) begin : g_dut
      logic [25*W_T[g]-1:0] os_w;
      keccak_perm_core #(.LANE_W(W_T[g]), .NUM_ROUNDS(NR_T[g]), .UNROLL(U_T[g])) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (ir_v[g]),
         .in_state  (in_state[25*W_T[g]-1:0]),
         .abort     (abort),
         .out_valid (ov_v[g]),
         .out_ready (out_ready),
         .out_state (os_w),
         .busy      (bz_v[g])
      );
      assign os_a[g] = 1600'(os_w);
   end

   // ---------------- reference model ----------------
   function automatic bit rc_bit(input int t);
      logic [8:0] r;
      r = 9'd1;
      for (int i = 1; i <= t % 255; i++) begin
         r = r << 1;
         if (r[8]) r = r ^ 9'h171;
      end
      return r[0];
   endfunction

   function automatic longint unsigned rotw(input longint unsigned v, input int r,
                                            input int w, input longint unsigned mask);
      if (r == 0) return v;
      return ((v << r) | (v >> (w - r))) & mask;
   endfunction

   function automatic logic [1599:0] model_perm(input logic [1599:0] s, input int w, input int nr);
      longint unsigned a [5][5];
      longint unsigned b [5][5];
      longint unsigned c [5];
      longint unsigned d [5];
      longint unsigned mask;
      int              rot [5][5];
      int              l, x, y, tx;
      logic [1599:0]   r;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      l = $clog2(w);
      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) rot[i][j] = 0;
      x = 1; y = 0;
      for (int t = 0; t < 24; t++) begin
         rot[x][y] = ((t + 1) * (t + 2) / 2) % w;
         tx = x; x = y; y = (2 * tx + 3 * y) % 5;
      end
      for (int j = 0; j < 5; j++)
         for (int i = 0; i < 5; i++)
            a[i][j] = 64'(s >> ((5 * j + i) * w)) & mask;
      for (int ir = 12 + 2 * l - nr; ir < 12 + 2 * l; ir++) begin
         for (int i = 0; i < 5; i++) c[i] = a[i][0] ^ a[i][1] ^ a[i][2] ^ a[i][3] ^ a[i][4];
         for (int i = 0; i < 5; i++) d[i] = c[(i + 4) % 5] ^ rotw(c[(i + 1) % 5], 1, w, mask);
         for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++)
            b[j][(2 * i + 3 * j) % 5] = rotw(a[i][j] ^ d[i], rot[i][j], w, mask);
         for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++)
            a[i][j] = (b[i][j] ^ (~b[(i + 1) % 5][j] & b[(i + 2) % 5][j])) & mask;
         for (int j = 0; j <= l; j++)
            a[0][0] = a[0][0] ^ (64'(rc_bit(j + 7 * ir)) << ((1 << j) - 1));
      end
      r = '0;
      for (int j = 0; j < 5; j++)
         for (int i = 0; i < 5; i++)
            r = r | (1600'(a[i][j]) << ((5 * j + i) * w));
      return r;
   endfunction

   function automatic logic [1599:0] rand_state();
      logic [1599:0] v;
      for (int i = 0; i < 50; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic int diff_word(input logic [1599:0] p, input logic [1599:0] q);
      for (int i = 0; i < 25; i++) if (p[i*64 +: 64] !== q[i*64 +: 64]) return i;
      return 0;
   endfunction

   // ---------------- scenarios ----------------
   task automatic run_perm(input logic [1599:0] s, input int hold, output logic [1599:0] cap0);
      logic [1599:0] exp_s [NCFG];
      int            lat   [NCFG];
      bit            all_done;
      int            dw;
      for (int g = 0; g < NCFG; g++) begin
         exp_s[g] = model_perm(s, W_T[g], NR_T[g]);
         lat[g]   = 0;
      end
      @(negedge clk); in_state = s; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk); in_valid = 1'b0;
      for (int g = 0; g < NCFG; g++) begin
         checks++;
         if (bz_v[g] !== 1'b1 || ir_v[g] !== 1'b0 || ov_v[g] !== 1'b0)
            $display("FAIL run_start cfg=%0d busy=%b in_ready=%b out_valid=%b want 1 0 0",
                     g, bz_v[g], ir_v[g], ov_v[g]);
         if (bz_v[g] !== 1'b1 || ir_v[g] !== 1'b0 || ov_v[g] !== 1'b0) errors++;
      end
      for (int c = 1; c <= 40; c++) begin
         all_done = 1'b1;
         for (int g = 0; g < NCFG; g++) begin
            if (lat[g] == 0 && ov_v[g] === 1'b1) lat[g] = c;
            if (lat[g] == 0) all_done = 1'b0;
         end
         if (all_done) break;
         @(negedge clk);
      end
      for (int g = 0; g < NCFG; g++) begin
         checks++;
         if (lat[g] !== NR_T[g] / U_T[g] + 1) begin
            errors++;
            $display("FAIL latency cfg=%0d got=%0d want=%0d", g, lat[g], NR_T[g] / U_T[g] + 1);
         end
      end
      cap0 = os_a[0];
      for (int h = 0; h <= hold; h++) begin
         for (int g = 0; g < NCFG; g++) begin
            checks++;
            if (ov_v[g] !== 1'b1 || ir_v[g] !== 1'b0 || os_a[g] !== exp_s[g]) begin
               errors++;
               dw = diff_word(os_a[g], exp_s[g]);
               $display("FAIL result cfg=%0d hold=%0d out_valid=%b in_ready=%b word%0d got=%h want=%h",
                        g, h, ov_v[g], ir_v[g], dw, os_a[g][dw*64 +: 64], exp_s[g][dw*64 +: 64]);
            end
         end
         if (h < hold) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
      for (int g = 0; g < NCFG; g++) begin
         checks++;
         if (ov_v[g] !== 1'b0 || ir_v[g] !== 1'b1) begin
            errors++;
            $display("FAIL release cfg=%0d out_valid=%b in_ready=%b want 0 1", g, ov_v[g], ir_v[g]);
         end
      end
   endtask

   task automatic check_idle_cleared(input string tag);
      for (int g = 0; g < NCFG; g++) begin
         checks++;
         if (ir_v[g] !== 1'b1 || ov_v[g] !== 1'b0 || bz_v[g] !== 1'b0 || os_a[g] !== '0) begin
            errors++;
            $display("FAIL %s cfg=%0d in_ready=%b out_valid=%b busy=%b state_nonzero=%b want 1 0 0 0",
                     tag, g, ir_v[g], ov_v[g], bz_v[g], |os_a[g]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      check_idle_cleared("reset_held");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_cleared("reset_released");
   endtask

   task automatic test_known_vector();
      logic [1599:0] first, second;
      run_perm('0, 0, first);
      checks++;
      if (first[63:0] !== 64'hF1258F7940E1DDE7) begin
         errors++;
         $display("FAIL kat_zero lane00 got=%h want=F1258F7940E1DDE7", first[63:0]);
      end
      run_perm(first, 0, second);
      checks++;
      if (second[63:0] !== 64'h2D5C954DF96ECB3C) begin
         errors++;
         $display("FAIL kat_chain lane00 got=%h want=2D5C954DF96ECB3C", second[63:0]);
      end
   endtask

   task automatic test_abort_idle();
      @(negedge clk); in_state = rand_state(); in_valid = 1'b1; abort = 1'b1;
      @(negedge clk); in_valid = 1'b0; abort = 1'b0;
      for (int g = 0; g < NCFG; g++) begin
         checks++;
         if (ir_v[g] !== 1'b1 || bz_v[g] !== 1'b0 || ov_v[g] !== 1'b0) begin
            errors++;
            $display("FAIL abort_priority cfg=%0d in_ready=%b busy=%b out_valid=%b want 1 0 0",
                     g, ir_v[g], bz_v[g], ov_v[g]);
         end
      end
   endtask

   task automatic test_random();
      logic [1599:0] cap;
      repeat (100) run_perm(rand_state(), 0, cap);
   endtask

   task automatic test_back_pressure();
      logic [1599:0] cap;
      run_perm(rand_state(), 50, cap);
   endtask

   task automatic test_abort();
      logic [1599:0] cap;
      @(negedge clk); in_state = rand_state(); in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      repeat (9) @(negedge clk);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check_idle_cleared("abort_run");
      run_perm(rand_state(), 0, cap);
   endtask

   task automatic test_reset_mid();
      logic [1599:0] cap;
      @(negedge clk); in_state = rand_state(); in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #2;
      check_idle_cleared("reset_mid");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check_idle_cleared("reset_mid_after");
      run_perm(rand_state(), 0, cap);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b0;
      in_state  = '0;
      test_reset();
      test_known_vector();
      test_abort_idle();
      test_random();
      test_back_pressure();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
